// File: rtl/relogio_display.sv
// relogio_display: snapshots a time-of-day value (hh:mm:ss.cc), converts each
// field to two BCD digits with a sequential shift-add-3 engine, and scans the
// eight committed digits onto a common-anode multiplexed 7-segment display.
// Ports:
//   clk, rst           - rising-edge clock, synchronous active-high reset
//   miliseconds[8:0]   - hundredths field (0..99)
//   seconds[7:0]       - seconds field (0..59)
//   minutes[7:0]       - minutes field (0..59)
//   hours[6:0]         - hours field (0..23)
//   load               - snapshot/convert request, level-sampled in IDLE
//   busy               - conversion in progress
//   bcd_valid          - one-cycle pulse when new digits are committed
//   seg[6:0]           - segments {g,f,e,d,c,b,a}, active-low
//   dp                 - decimal point, active-low
//   an[7:0]            - digit enables, active-low; an[0] = hundredths units
module relogio_display #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter logic [7:0]  DP_MASK  = 8'b01010100,
  parameter bit          BLANK_LZ = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] miliseconds,
  input  logic [7:0] seconds,
  input  logic [7:0] minutes,
  input  logic [6:0] hours,
  input  logic       load,
  output logic       busy,
  output logic       bcd_valid,
  output logic [6:0] seg,
  output logic       dp,
  output logic [7:0] an
);

  localparam int unsigned PRE_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FLD_W  = 7;
  localparam int unsigned SH_W   = 15;
  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(SCAN_DIV - 1);
  localparam logic [3:0] DASH   = 4'hA;
  localparam logic [2:0] BIT_TC = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0][FLD_W-1:0] r_snap;
  logic [3:0]            r_clamp;
  logic [2:0]            r_bit;
  logic [1:0]            r_fld;
  logic [SH_W-1:0]       r_sh;
  logic [3:0][7:0]       r_conv;
  logic [7:0][3:0]       r_dig;
  logic [SH_W-1:0]       w_src;
  logic [SH_W-1:0]       w_adj;
  logic [SH_W-1:0]       w_shift;
  logic [PRE_W-1:0]      r_pre;
  logic [2:0]            r_idx;
  logic                  w_pre_tc;
  logic [2:0]            w_idx_nxt;
  logic [3:0]            w_dig_sel;
  logic [6:0]            w_seg_nxt;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state: 28 shift cycles (4 fields x 7 bits) then one commit cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (load) w_state_nxt = S_CONV;
      S_CONV:   if (r_bit == BIT_TC && r_fld == 2'd3) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // One shift-add-3 step; the first step of each field loads its binary value
  always_comb begin
    w_src = (r_bit == 3'd0) ? {8'd0, r_snap[r_fld]} : r_sh;
    w_adj = w_src;
    if (w_src[10:7] >= 4'd5)  w_adj[10:7]  = w_src[10:7] + 4'd3;
    if (w_src[14:11] >= 4'd5) w_adj[14:11] = w_src[14:11] + 4'd3;
    w_shift = w_adj << 1;
  end

  // Snapshot, conversion datapath and atomic commit of all eight digits
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      bcd_valid <= 1'b0;
      r_snap    <= '0;
      r_clamp   <= '0;
      r_bit     <= '0;
      r_fld     <= '0;
      r_sh      <= '0;
      r_conv    <= '0;
      r_dig     <= '0;
    end else begin
      bcd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            busy       <= 1'b1;
            r_snap[0]  <= miliseconds[6:0];
            r_snap[1]  <= seconds[6:0];
            r_snap[2]  <= minutes[6:0];
            r_snap[3]  <= hours;
            // Out-of-range fields are flagged now, using the full input width
            r_clamp[0] <= (miliseconds > 9'd99);
            r_clamp[1] <= (seconds > 8'd99);
            r_clamp[2] <= (minutes > 8'd99);
            r_clamp[3] <= (hours > 7'd99);
            r_bit      <= '0;
            r_fld      <= '0;
          end
        end
        S_CONV: begin
          r_sh <= w_shift;
          if (r_bit == BIT_TC) begin
            r_conv[r_fld] <= w_shift[14:7];
            r_bit         <= '0;
            r_fld         <= r_fld + 2'd1;
          end else begin
            r_bit <= r_bit + 3'd1;
          end
        end
        S_COMMIT: begin
          busy      <= 1'b0;
          bcd_valid <= 1'b1;
          for (int f = 0; f < 4; f++) begin
            r_dig[2*f]   <= r_clamp[f] ? DASH : r_conv[f][3:0];
            r_dig[2*f+1] <= r_clamp[f] ? DASH : r_conv[f][7:4];
          end
        end
        default: ;
      endcase
    end
  end

  // Scan index advance and segment decode of the digit about to be shown
  always_comb begin
    w_pre_tc  = (r_pre == PRE_TC);
    w_idx_nxt = w_pre_tc ? r_idx + 3'd1 : r_idx;
    w_dig_sel = r_dig[w_idx_nxt];
    case (w_dig_sel)
      4'd0:    w_seg_nxt = 7'b1000000;
      4'd1:    w_seg_nxt = 7'b1111001;
      4'd2:    w_seg_nxt = 7'b0100100;
      4'd3:    w_seg_nxt = 7'b0110000;
      4'd4:    w_seg_nxt = 7'b0011001;
      4'd5:    w_seg_nxt = 7'b0010010;
      4'd6:    w_seg_nxt = 7'b0000010;
      4'd7:    w_seg_nxt = 7'b1111000;
      4'd8:    w_seg_nxt = 7'b0000000;
      4'd9:    w_seg_nxt = 7'b0010000;
      DASH:    w_seg_nxt = 7'b0111111;
      default: w_seg_nxt = 7'b1111111;
    endcase
    if (BLANK_LZ && w_idx_nxt == 3'd7 && w_dig_sel == 4'd0) w_seg_nxt = 7'b1111111;
  end

  // Free-running scan; independent of conversion activity
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
      an    <= 8'b11111110;
      seg   <= 7'b1000000;
      dp    <= ~DP_MASK[0];
    end else begin
      r_pre <= w_pre_tc ? '0 : r_pre + PRE_W'(1);
      r_idx <= w_idx_nxt;
      an    <= ~(8'd1 << w_idx_nxt);
      seg   <= w_seg_nxt;
      dp    <= ~DP_MASK[w_idx_nxt];
    end
  end

endmodule

// File: tb/tb_relogio_display.sv
// tb_relogio_display: scoreboard bench for relogio_display. A reference model
// on the rising edge predicts conversion timing and pushes expected digit sets;
// a monitor on the falling edge checks busy/bcd_valid/scan outputs and pops the
// scoreboard whenever the DUT pulses bcd_valid.
module tb_relogio_display;

  localparam int unsigned SCAN_DIV = 4;
  localparam logic [7:0]  DP_MASK  = 8'b01010100;
  localparam logic [3:0]  DASH     = 4'hA;

  logic       clk;
  logic       rst;
  logic [8:0] miliseconds;
  logic [7:0] seconds;
  logic [7:0] minutes;
  logic [6:0] hours;
  logic       load;
  logic       busy;
  logic       bcd_valid;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] an;

  int checks   = 0;
  int failures = 0;

  relogio_display #(
    .SCAN_DIV (SCAN_DIV),
    .DP_MASK  (DP_MASK),
    .BLANK_LZ (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .miliseconds (miliseconds),
    .seconds     (seconds),
    .minutes     (minutes),
    .hours       (hours),
    .load        (load),
    .busy        (busy),
    .bcd_valid   (bcd_valid),
    .seg         (seg),
    .dp          (dp),
    .an          (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Digit i of a display image lives in bits [4i+3:4i]
  function automatic logic [31:0] ref_digits(input int ms, input int s, input int m, input int h);
    int v [4];
    logic [31:0] r;
    v[0] = ms; v[1] = s; v[2] = m; v[3] = h;
    r = '0;
    for (int f = 0; f < 4; f++) begin
      if (v[f] > 99) begin
        r[8*f +: 4]     = DASH;
        r[8*f + 4 +: 4] = DASH;
      end else begin
        r[8*f +: 4]     = 4'(v[f] % 10);
        r[8*f + 4 +: 4] = 4'(v[f] / 10);
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] ref_seg(input logic [3:0] d, input int idx);
    if (idx == 7 && d == 4'd0) return 7'h7F;
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      4'hA: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference model state
  logic [31:0] sb_q[$];
  int          m_rem   = 0;
  bit          m_valid = 1'b0;
  int          k_cyc   = 0;
  bit          started = 1'b0;
  logic [31:0] m_dig   = '0;

  // Reference model: busy lasts 29 cycles from the accepting edge, commit on the last
  always @(posedge clk) begin
    if (rst) begin
      started = 1'b1;
      m_rem   = 0;
      m_valid = 1'b0;
      k_cyc   = 0;
      m_dig   = '0;
      sb_q.delete();
    end else begin
      m_valid = (m_rem == 1);
      if (m_rem > 0) m_rem--;
      else if (load) begin
        m_rem = 29;
        sb_q.push_back(ref_digits(int'(miliseconds), int'(seconds), int'(minutes), int'(hours)));
      end
      k_cyc++;
    end
  end

  // Monitor
  int         mi_idx;
  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  always @(negedge clk) begin
    if (started) begin
      mi_idx = (k_cyc / int'(SCAN_DIV)) % 8;
      e_an   = ~(8'd1 << mi_idx);
      e_seg  = ref_seg(m_dig[4*mi_idx +: 4], mi_idx);
      e_dp   = ~DP_MASK[mi_idx];
      checks++;
      if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
        failures++;
        $display("FAIL scan t=%0t an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                 $time, an, seg, dp, e_an, e_seg, e_dp);
      end
      checks++;
      if (busy !== (m_rem > 0)) begin
        failures++;
        $display("FAIL busy t=%0t got=%b required=%b", $time, busy, (m_rem > 0));
      end
      checks++;
      if (bcd_valid !== m_valid) begin
        failures++;
        $display("FAIL bcd_valid t=%0t got=%b required=%b", $time, bcd_valid, m_valid);
      end
      if (bcd_valid === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL commit_unexpected t=%0t got=bcd_valid required=no_pending", $time);
        end else begin
          m_dig = sb_q.pop_front();
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_time(input int ms, input int s, input int m, input int h);
    miliseconds = 9'(ms);
    seconds     = 8'(s);
    minutes     = 8'(m);
    hours       = 7'(h);
  endtask

  task automatic pulse_load(input int len);
    load = 1'b1;
    tick(len);
    load = 1'b0;
  endtask

  task automatic rand_time();
    set_time(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 99)),
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 59)),
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 59)),
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 23)));
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    set_time(0, 0, 0, 0);
    tick(3);
    rst = 1'b0;
    tick(40);

    // Full-scale directed value
    set_time(99, 58, 59, 23);
    pulse_load(1);
    tick(60);

    // load held high with inputs changing every cycle
    load = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_time();
      tick(1);
    end
    load = 1'b0;
    tick(60);

    // Out-of-range hundredths
    set_time(300, 0, 0, 0);
    pulse_load(1);
    tick(60);

    // Reset in the middle of a conversion
    set_time(87, 45, 12, 19);
    pulse_load(1);
    tick(13);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(40);

    // Leading-zero blanking on hours tens
    set_time(7, 30, 42, 5);
    pulse_load(1);
    tick(60);

    // Randomized transactions, load bursts while busy, occasional reset
    for (int i = 0; i < 30; i++) begin
      rand_time();
      pulse_load(int'($urandom_range(1, 3)));
      tick(int'($urandom_range(0, 50)));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
    end
    tick(70);

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/relogio_display.md
Name: relogio_display

Overview:
- Display stage directly downstream of the time-of-day counter (hours, minutes, seconds, hundredths).
- On a load strobe it snapshots the four binary fields and converts each to two BCD digits with a sequential shift-add-3 engine.
- It then scans the eight digits onto a common-anode multiplexed 7-segment display, digit order HH MM SS cc.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit stays lit (minimum 2).
- DP_MASK, 8'b01010100, per-digit decimal point enable; bit i = digit i; 1 = point lit.
- BLANK_LZ, 0, when 1 the hours-tens digit is blanked if it is 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- miliseconds  in  9  hundredths field, binary, valid 0..99.
- seconds  in  8  seconds field, binary, valid 0..59.
- minutes  in  8  minutes field, binary, valid 0..59.
- hours  in  7  hours field, binary, valid 0..23.
- load  in  1  snapshot/convert request, level-sampled each cycle.
- busy  out  1  conversion in progress.
- bcd_valid  out  1  one-cycle pulse when new digits are committed.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  8  digit enables, active-low; an[0] = hundredths units (rightmost), an[7] = hours tens.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state changes on posedge clk.
  - rst is synchronous and active-high, and overrides everything, including mid-conversion.
- Reset values:
  - busy=0, bcd_valid=0, FSM=IDLE, scan index=0, prescaler=0.
  - All eight committed digits=0.
  - an=8'b11111110, seg=7'b1000000 ('0'), dp=~DP_MASK[0].
- FSM states: IDLE, CONV, COMMIT.
- IDLE:
  - If load=1 at edge N, latch all four inputs into snapshot registers and go to CONV.
  - busy=1 from edge N onward.
- CONV:
  - Fields are processed in order hundredths, seconds, minutes, hours.
  - Each field uses its low 7 bits and takes exactly 7 shift cycles; before each shift, any BCD nibble >=5 gets +3.
  - Total CONV = 28 cycles.
- Out-of-range fields:
  - A snapshot field >99 (hundredths field, any of bits 8..0) forces both of its digits to DASH (segment g only, seg=7'b0111111).
  - The clamp is decided at latch time.
- COMMIT:
  - At edge N+29, all eight digits update atomically; bcd_valid=1 for that one cycle.
  - Next state is IDLE; busy=0 after edge N+29.
  - busy is high for exactly 29 cycles.
- load while busy: ignored, not queued. load held high re-triggers in IDLE on the cycle after COMMIT.
- Display is glitch-free: the scan always shows committed digits, never partial conversion results.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1; at terminal count it wraps to 0 and the scan index increments mod 8 (7 -> 0).
  - an, seg and dp are registered and change on the same edge as the index.
  - Exactly one an bit is low at any time.
- Decode, digits 0-9: standard patterns, e.g. '1'=7'b1111001, '8'=7'b0000000.
- Blanking:
  - BLANK_LZ=1 and hours tens=0 -> seg=7'h7F for that digit.
  - dp is still governed by DP_MASK.
- dp equals ~DP_MASK[index].
- Conversion and scanning run independently; the scan is never stalled by busy.

Test Plan:
1. Reset, SCAN_DIV=4: hold rst 3 cycles -> an=8'hFE, seg=7'h40, busy=0. After 4 cycles an=8'hFD. After 32 cycles an back at 8'hFE.
2. hours=23, minutes=59, seconds=58, miliseconds=99; pulse load at edge N:
   - busy high edges N..N+28;
   - bcd_valid pulses exactly at edge N+29;
   - committed digits read 2,3,5,9,5,8,9,9 (an[7]..an[0]);
   - digit 7 seg=7'b0100100.
3. load held high continuously -> a new conversion starts every 30 cycles. Changing inputs during CONV do not alter the result, which reflects values at the latch edge.
4. miliseconds=9'd300, others 0; load -> digits 1,0 show 7'b0111111. Remaining digits show '0'.
5. Assert rst at CONV cycle 14 -> busy=0 next cycle, no bcd_valid pulse, digits all '0'.
6. BLANK_LZ=1, hours=5; load -> digit 7 seg=7'h7F, digit 6 seg=7'b0010010. With DP_MASK default, dp=0 only on indices 2, 4 and 6.
